// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the accumulator ALU controller: opcodes, FSM states
// and the default datapath width.
package alu_ctrl_pkg;

  localparam int ALU_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_ACC_ADD = 3'b100,
    OP_ACC_SUB = 3'b101,
    OP_ACC_CLR = 3'b110,
    OP_ACC_LD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Accumulating arithmetic takes its A operand from the accumulator.
  function automatic logic op_uses_acc(input op_e op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
  endfunction

  // Every ACC_* opcode leaves its result in the accumulator.
  function automatic logic op_writes_acc(input op_e op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB) ||
           (op == OP_ACC_CLR) || (op == OP_ACC_LD);
  endfunction

endpackage

// File: rtl/alu16_core.sv
// Purely combinational ALU: add/sub with carry-borrow and signed overflow,
// bitwise AND/OR, clear and pass-through of A.
module alu16_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             z,
  output logic             o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    c   = 1'b0;
    o   = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_ACC_ADD: begin
        res = w_sum[WIDTH-1:0];
        c   = w_sum[WIDTH];
        // Same-sign operands producing an opposite-sign result
        o   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_ACC_SUB: begin
        res = w_diff[WIDTH-1:0];
        c   = w_diff[WIDTH];
        o   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:     res = a & b;
      OP_OR:      res = a | b;
      OP_ACC_CLR: res = '0;
      OP_ACC_LD:  res = a;
      default:    res = '0;
    endcase
  end

  assign z = (res == '0);

endmodule

// File: rtl/alu_ctrl.sv
// Command/response wrapper around alu16_core: IDLE->EXEC->RESP handshake FSM,
// operand and response registers, accumulator and completed-response counter.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_o,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       op_cnt
);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_cmd_ready;
  logic             w_rsp_valid;
  logic             w_accept;
  logic             w_done;

  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp_res;
  logic             r_rsp_c;
  logic             r_rsp_z;
  logic             r_rsp_o;
  logic [WIDTH-1:0] r_acc;
  logic [7:0]       r_op_cnt;

  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_z;
  logic             w_alu_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept = w_cmd_ready & cmd_valid;
  assign w_done   = w_rsp_valid & rsp_ready;
  assign w_alu_a  = op_uses_acc(r_op) ? r_acc : r_a;

  alu16_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (w_alu_a),
    .b  (r_b),
    .op (r_op),
    .res(w_alu_res),
    .c  (w_alu_c),
    .z  (w_alu_z),
    .o  (w_alu_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_rsp_res <= '0;
      r_rsp_c   <= 1'b0;
      r_rsp_z   <= 1'b0;
      r_rsp_o   <= 1'b0;
      r_acc     <= '0;
      r_op_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_op <= op_e'(cmd_op);
        r_a  <= cmd_a;
        r_b  <= cmd_b;
      end
      // The core's result is exactly the new accumulator value for ACC_* ops
      if (r_state == ST_EXEC) begin
        r_rsp_res <= w_alu_res;
        r_rsp_c   <= w_alu_c;
        r_rsp_z   <= w_alu_z;
        r_rsp_o   <= w_alu_o;
        if (op_writes_acc(r_op)) r_acc <= w_alu_res;
      end
      if (w_done) r_op_cnt <= r_op_cnt + 8'd1;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_c     = r_rsp_c;
  assign rsp_z     = r_rsp_z;
  assign rsp_o     = r_rsp_o;
  assign acc       = r_acc;
  assign op_cnt    = r_op_cnt;

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  block can accept command.
REQ-006 cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ACC_ADD, 101 ACC_SUB, 110 ACC_CLR, 111 ACC_LD.
REQ-007 cmd_a  in  WIDTH  operand A.
REQ-008 cmd_b  in  WIDTH  operand B.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_res  out  WIDTH  result.
REQ-012 rsp_c, rsp_z, rsp_o  out  1 each  carry/borrow, zero, signed overflow.
REQ-013 acc  out  WIDTH  current accumulator value.
REQ-014 op_cnt  out  8  count of completed responses.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 IDLE: cmd_ready=1; on cmd_valid=1 SHALL latch cmd_op/cmd_a/cmd_b and go to EXEC.
REQ-017 EXEC: cmd_ready=0; SHALL capture ALU outputs into rsp_* registers, update acc per REQ-022..024, go to RESP (exactly one cycle).
REQ-018 RESP: rsp_valid=1, rsp_* stable; on rsp_ready=1 SHALL go to IDLE and increment op_cnt; else hold.
REQ-019 Latency: command accepted at edge N -> rsp_valid high after edge N+2; max throughput one command per 3 cycles.
REQ-020 cmd_ready SHALL be 0 in EXEC and RESP; cmd inputs ignored there.
REQ-021 ADD/SUB: {c,res} = {0,A} +/- {0,B} in WIDTH+1 bits; c = bit WIDTH (borrow for SUB); o = two's-complement signed overflow of the WIDTH-bit operation.
REQ-022 AND/OR: res = A&B / A|B; c=0, o=0; acc unchanged.
REQ-023 ACC_ADD/ACC_SUB: operand A replaced by acc; flags per REQ-021; acc <= res in EXEC.
REQ-024 ACC_CLR: acc <= 0, res=0, c=0, o=0. ACC_LD: acc <= cmd_a, res=cmd_a, c=0, o=0.
REQ-025 z SHALL be 1 iff res == 0, for every opcode.
REQ-026 op_cnt SHALL wrap 255 -> 0.
REQ-027 rsp_valid and rsp_ready both high in same cycle with new cmd_valid: command not accepted until IDLE (next cycle).

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_res=0, rsp_c=rsp_z=rsp_o=0, acc=0, op_cnt=0; cmd_ready=1 while in IDLE after release.
REQ-029 Reset asserted in EXEC or RESP SHALL discard the in-flight command; no response, no acc update.

Structure
REQ-030 Shared package SHALL hold opcode constants (3-bit encodings of REQ-006), FSM state encoding, default WIDTH.
REQ-031 Combinational arithmetic SHALL live in one sub-module alu16_core (inputs a, b, op; outputs res, c, z, o), instantiated once.
REQ-032 alu_ctrl SHALL contain only FSM, operand/response registers, accumulator, and counter.

Verification
REQ-033 Reset then ADD A=0x7FFF B=0x0001 -> rsp_res=0x8000, c=0, z=0, o=1, rsp_valid 2 cycles after accept.
REQ-034 SUB A=0x0000 B=0x0001 -> rsp_res=0xFFFF, c=1, z=0, o=0; SUB A=0x1234 B=0x1234 -> res=0, z=1, c=0.
REQ-035 ACC_LD A=0xFFFF, then ACC_ADD B=0x0001 -> res=0x0000, c=1, z=1, o=0, acc=0x0000; ACC_CLR -> acc=0, z=1.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0, op_cnt unchanged until release, then +1.
REQ-037 rst_n pulsed low during EXEC of ACC_ADD -> no rsp_valid, acc=0, op_cnt=0, cmd_ready=1 after release.
REQ-038 256 back-to-back AND commands with rsp_ready=1 -> op_cnt wraps to 0; each res=A&B, c=o=0.
